rr_arb_wrr: RTL and testbench

//  Sequential weighted round-robin arbiter with packet lock for switch ingress/egress muxes.

---
 rtl/rr_arb_wrr_pkg.sv | 17 +
 rtl/rr_arb_wrr_ppe.sv | 78 +++++++
 rtl/rr_arb_wrr.sv | 134 +++++++++++++
 tb/tb_rr_arb_wrr.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_wrr_pkg.sv
// Purpose: shared state encoding and pointer helper for the weighted round-robin arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rr_arb_wrr_pkg;

  // Two-state arbiter: waiting for any request, or holding a packet grant.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Next round-robin position after index ptr, wrapping n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arb_wrr_ppe.sv
// Purpose: programmable priority encoder (lowest set index at/after ptr, else lowest overall).
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.

// Fixed-priority encoder: lowest set bit wins.
module prio_enc #(
  parameter int W   = 4,
  parameter int WL2 = 2
) (
  input  logic [W-1:0]   i_vec,
  output logic           o_any,
  output logic [W-1:0]   o_onehot,
  output logic [WL2-1:0] o_bin
);

  assign o_any    = |i_vec;
  assign o_onehot = i_vec & (~i_vec + W'(1));

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_bin = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_bin = WL2'(i);
    end
  end

endmodule

module wrr_ppe #(
  parameter int N   = 4,
  parameter int NL2 = 2
) (
  input  logic [N-1:0]   i_vec,
  input  logic [NL2-1:0] i_ptr,
  output logic           o_any,
  output logic [N-1:0]   o_onehot,
  output logic [NL2-1:0] o_bin
);

  logic [N-1:0]   w_mask;
  logic [N-1:0]   w_masked;
  logic           w_m_any;
  logic [N-1:0]   w_m_onehot;
  logic [NL2-1:0] w_m_bin;
  logic           w_u_any;
  logic [N-1:0]   w_u_onehot;
  logic [NL2-1:0] w_u_bin;

  // Keep only candidates at or above the priority pointer.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  assign w_masked = i_vec & w_mask;

  prio_enc #(.W(N), .WL2(NL2)) u_masked (
    .i_vec    (w_masked),
    .o_any    (w_m_any),
    .o_onehot (w_m_onehot),
    .o_bin    (w_m_bin)
  );

  prio_enc #(.W(N), .WL2(NL2)) u_unmasked (
    .i_vec    (i_vec),
    .o_any    (w_u_any),
    .o_onehot (w_u_onehot),
    .o_bin    (w_u_bin)
  );

  // Masked hit wins; otherwise wrap around to the lowest requester.
  assign o_any    = w_u_any;
  assign o_onehot = w_m_any ? w_m_onehot : w_u_onehot;
  assign o_bin    = w_m_any ? w_m_bin    : w_u_bin;

endmodule

// File: rtl/rr_arb_wrr.sv
// Purpose: weighted round-robin arbiter holding each grant for whole packets (weight+1 per turn).
// Latency: 1 cycle from req to registered grant; zero-bubble hand-off at eop when others wait.
// Backpressure: gnt_ready low stalls the packet; grant and credit are held until the beat moves.
module rr_arb_wrr
  import rr_arb_wrr_pkg::*;
#(
  parameter int RR_WIDTH    = 4,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
  parameter int WGT_W       = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [RR_WIDTH-1:0]       req,
  input  logic [RR_WIDTH-1:0]       last,
  input  logic [RR_WIDTH*WGT_W-1:0] weight,
  input  logic                      gnt_ready,
  output logic                      gnt_valid,
  output logic [RR_WIDTH-1:0]       gnt_vec,
  output logic [RR_WIDTH_L2-1:0]    gnt_bin
);

  state_t                 r_state;
  logic [RR_WIDTH_L2-1:0] r_ptr;
  logic [RR_WIDTH-1:0]    r_gnt_vec;
  logic [RR_WIDTH_L2-1:0] r_gnt_bin;
  logic [WGT_W-1:0]       r_credit;
  logic                   r_pkt_start;

  logic                   w_sel_req;
  logic                   w_gnt_valid;
  logic                   w_xfer;
  logic                   w_eop;
  logic [RR_WIDTH_L2-1:0] w_ptr_nxt;
  logic [RR_WIDTH-1:0]    w_oth;

  logic                   w_idle_any;
  logic [RR_WIDTH-1:0]    w_idle_onehot;
  logic [RR_WIDTH_L2-1:0] w_idle_bin;
  logic [WGT_W-1:0]       w_idle_wgt;

  logic                   w_ho_any;
  logic [RR_WIDTH-1:0]    w_ho_onehot;
  logic [RR_WIDTH_L2-1:0] w_ho_bin;
  logic [WGT_W-1:0]       w_ho_wgt;

  assign w_sel_req   = |(r_gnt_vec & req);
  assign w_gnt_valid = (r_state == ST_GRANT) & w_sel_req;
  assign w_xfer      = w_gnt_valid & gnt_ready;
  assign w_eop       = w_xfer & |(r_gnt_vec & last);
  assign w_ptr_nxt   = RR_WIDTH_L2'(wrap_inc(32'(r_gnt_bin), RR_WIDTH));
  assign w_oth       = req & ~r_gnt_vec;

  assign gnt_valid = w_gnt_valid;
  assign gnt_vec   = r_gnt_vec;
  assign gnt_bin   = r_gnt_bin;

  // Fresh arbitration out of IDLE, starting from the stored pointer.
  wrr_ppe #(.N(RR_WIDTH), .NL2(RR_WIDTH_L2)) u_ppe_idle (
    .i_vec    (req),
    .i_ptr    (r_ptr),
    .o_any    (w_idle_any),
    .o_onehot (w_idle_onehot),
    .o_bin    (w_idle_bin)
  );

  // Hand-off arbitration at credit exhaustion, using the already-advanced pointer.
  wrr_ppe #(.N(RR_WIDTH), .NL2(RR_WIDTH_L2)) u_ppe_ho (
    .i_vec    (w_oth),
    .i_ptr    (w_ptr_nxt),
    .o_any    (w_ho_any),
    .o_onehot (w_ho_onehot),
    .o_bin    (w_ho_bin)
  );

  // Pick out the weight field of whichever requester each path would grant.
  always_comb begin
    w_idle_wgt = '0;
    w_ho_wgt   = '0;
    for (int i = 0; i < RR_WIDTH; i++) begin
      if (w_idle_bin == RR_WIDTH_L2'(i)) w_idle_wgt = weight[i*WGT_W +: WGT_W];
      if (w_ho_bin   == RR_WIDTH_L2'(i)) w_ho_wgt   = weight[i*WGT_W +: WGT_W];
    end
  end

  // Arbiter FSM: grant load, packet tracking, credit countdown and pointer advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt_vec   <= '0;
      r_gnt_bin   <= '0;
      r_credit    <= '0;
      r_pkt_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_any) begin
            r_gnt_vec   <= w_idle_onehot;
            r_gnt_bin   <= w_idle_bin;
            r_credit    <= w_idle_wgt;
            r_pkt_start <= 1'b1;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (r_pkt_start && !w_sel_req) begin
            // Requester withdrew before its packet began: give up the turn.
            r_ptr     <= w_ptr_nxt;
            r_gnt_vec <= '0;
            r_state   <= ST_IDLE;
          end else if (w_eop && (r_credit != '0)) begin
            r_credit    <= r_credit - WGT_W'(1);
            r_pkt_start <= 1'b1;
          end else if (w_eop) begin
            r_ptr <= w_ptr_nxt;
            if (w_ho_any) begin
              r_gnt_vec   <= w_ho_onehot;
              r_gnt_bin   <= w_ho_bin;
              r_credit    <= w_ho_wgt;
              r_pkt_start <= 1'b1;
            end else begin
              r_gnt_vec <= '0;
              r_state   <= ST_IDLE;
            end
          end else if (w_xfer) begin
            r_pkt_start <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_wrr.sv
// Purpose: self-checking bench for rr_arb_wrr: vector table, directed corner sequences, random vs model.
// Latency: outputs sampled 1 time unit after the falling edge, inputs driven at the falling edge.
// Backpressure: gnt_ready driven per vector / randomly.
module tb_rr_arb_wrr;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic [N*W-1:0] weight;
  logic           gnt_ready;
  logic           gnt_valid;
  logic [N-1:0]   gnt_vec;
  logic [1:0]     gnt_bin;

  int errors = 0;
  int checks = 0;

  // Reference model state: granted index (-1 none), pointer, packets left in turn, mid-packet flag.
  int m_sel;
  int m_ptr;
  int m_left;
  bit m_mid;

  typedef struct {
    logic [3:0] r;
    logic [3:0] l;
    logic       rdy;
    logic       vld;
    logic [3:0] vec;
    logic [1:0] bin;
  } vec_t;

  vec_t tbl[10];

  rr_arb_wrr #(.RR_WIDTH(N), .RR_WIDTH_L2(2), .WGT_W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .last      (last),
    .weight    (weight),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt_vec   (gnt_vec),
    .gnt_bin   (gnt_bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle of inputs, check the current outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] l, input logic rd,
                     input logic ev, input logic [3:0] evec, input logic [1:0] ebin);
    req = r; last = l; gnt_ready = rd;
    #1;
    chk({tag, "/vld"}, 32'(gnt_valid), 32'(ev));
    chk({tag, "/vec"}, 32'(gnt_vec), 32'(evec));
    if (evec != 4'h0) chk({tag, "/bin"}, 32'(gnt_bin), 32'(ebin));
    step();
  endtask

  task automatic do_reset(input logic [N*W-1:0] wgt);
    weight = wgt;
    rstn = 1'b0; req = '0; last = '0; gnt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Rotating scan from p: first set index at or after p, wrapping.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int wgt_of(input int s);
    return int'(weight[s*W +: W]);
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    logic [3:0] oth;
    bit xfer;
    if (m_sel < 0) begin
      if (r != 4'h0) begin
        m_sel = pick(r, m_ptr); m_left = wgt_of(m_sel) + 1; m_mid = 0;
      end
    end else begin
      xfer = r[m_sel] && rdy;
      if (!m_mid && !r[m_sel]) begin
        m_ptr = (m_sel + 1) % N; m_sel = -1;
      end else if (xfer && l[m_sel]) begin
        m_left--; m_mid = 0;
        if (m_left == 0) begin
          m_ptr = (m_sel + 1) % N;
          oth = r; oth[m_sel] = 1'b0;
          if (oth != 4'h0) begin
            m_sel = pick(oth, m_ptr); m_left = wgt_of(m_sel) + 1;
          end else begin
            m_sel = -1;
          end
        end
      end else if (xfer) begin
        m_mid = 1;
      end
    end
  endtask

  initial begin
    // Equal weights, 1-beat packets: round robin 0..3 back to back, then release and pointer wrap.
    tbl[0] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 2'd1};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 2'd2};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 2'd3};
    tbl[5] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0};
    tbl[6] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 2'd1};
    tbl[7] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[8] = '{4'h3, 4'h3, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[9] = '{4'h3, 4'h3, 1'b1, 1'b1, 4'h1, 2'd0};

    // Reset state with every requester asserted.
    weight = '0;
    rstn = 1'b0; req = 4'hF; last = 4'hF; gnt_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst/vld", 32'(gnt_valid), 32'd0);
    chk("rst/vec", 32'(gnt_vec), 32'd0);
    chk("rst/bin", 32'(gnt_bin), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].r, tbl[i].l, tbl[i].rdy, tbl[i].vld, tbl[i].vec, tbl[i].bin);
    end

    // Weight 2 on requester 1 alone: three packets, IDLE bubble, then re-grant.
    do_reset(16'h0020);
    cyc("w2/idle", 4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("w2/p1",   4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);
    cyc("w2/p2",   4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);
    cyc("w2/p3",   4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);
    cyc("w2/gap",  4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("w2/re",   4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);

    // 4-beat packet on req2 with req0 arriving mid-packet: no pre-emption, zero-bubble hand-off.
    do_reset(16'h0000);
    cyc("lk/idle", 4'h4, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("lk/b1",   4'h4, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2);
    cyc("lk/b2",   4'h5, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2);
    cyc("lk/b3",   4'h5, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2);
    cyc("lk/b4",   4'h5, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2);
    cyc("lk/ho",   4'h1, 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);

    // Backpressure mid-packet: last on a stalled beat must not count, credit 1 gives two packets.
    do_reset(16'h0001);
    cyc("bp/idle", 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("bp/b1",   4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc("bp/s1",   4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 2'd0);
    cyc("bp/b2",   4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc("bp/s2",   4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 2'd0);
    cyc("bp/eop1", 4'h1, 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc("bp/pkt2", 4'h1, 4'h1, 1'b1, 1'b1, 4'h1, 2'd0);
    cyc("bp/done", 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0);

    // Asynchronous reset at beat 2 of a packet, after the pointer has moved to 2.
    do_reset(16'h0000);
    cyc("ar/idle", 4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("ar/p1",   4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1);
    cyc("ar/idl2", 4'h4, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("ar/b1",   4'h4, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2);
    req = 4'h4; last = 4'h0; gnt_ready = 1'b1;
    #1;
    chk("ar/b2vec", 32'(gnt_vec), 32'h4);
    rstn = 1'b0;
    #1;
    chk("ar/asyvec", 32'(gnt_vec), 32'h0);
    chk("ar/asyvld", 32'(gnt_valid), 32'h0);
    chk("ar/asybin", 32'(gnt_bin), 32'h0);
    step();
    rstn = 1'b1;
    cyc("ar/post",  4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0);
    cyc("ar/ptr0",  4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0);

    // Randomized traffic against the reference model; holds req through started packets.
    do_reset(16'h0000);
    m_sel = -1; m_ptr = 0; m_left = 0; m_mid = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] r;
      logic [3:0] l;
      logic       rdy;
      logic [3:0] evec;
      if (c % 250 == 0) begin
        for (int i = 0; i < N; i++) weight[i*W +: W] = W'($urandom_range(0, 3));
      end
      r   = 4'($urandom_range(0, 15));
      if (m_sel >= 0 && m_mid) r[m_sel] = 1'b1;
      l   = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      req = r; last = l; gnt_ready = rdy;
      #1;
      evec = (m_sel >= 0) ? 4'(1 << m_sel) : 4'h0;
      chk($sformatf("rnd%0d/vec", c), 32'(gnt_vec), 32'(evec));
      chk($sformatf("rnd%0d/vld", c), 32'(gnt_valid), (m_sel >= 0 && r[m_sel]) ? 32'd1 : 32'd0);
      if (m_sel >= 0) chk($sformatf("rnd%0d/bin", c), 32'(gnt_bin), 32'(m_sel));
      model_step(r, l, rdy);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
